// File: rtl/iomem_bus_ctrl_pkg.sv
// Shared types and helpers for the iomem bus controller: FSM state encoding,
// default error read data and the page decode used to pick a slot.
package iomem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    ERR
  } state_t;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

  // Nine-bit compare so BASE_PAGE near 8'hFF cannot wrap the upper bound.
  function automatic logic page_hit(input logic [7:0] addr_page,
                                    input logic [7:0] base,
                                    input int unsigned n);
    logic [8:0] page;
    logic [8:0] lo;
    logic [8:0] hi;
    page = {1'b0, addr_page};
    lo   = {1'b0, base};
    hi   = lo + 9'(n);
    return (page >= lo) && (page < hi);
  endfunction

endpackage

// File: rtl/iomem_bus_ctrl_if.sv
// CPU-side picosoc iomem handshake; master is the CPU, slave is the controller.
interface iomem_bus_ctrl_if;

  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );

endinterface

// File: rtl/iomem_bus_ctrl.sv
// Routes the single iomem request to one of NSLOT page-decoded slots, waits for
// the slot ack, and terminates unacked or unmapped accesses with an error response.
module iomem_bus_ctrl
  import iomem_bus_pkg::*;
#(
  parameter int          NSLOT     = 4,
  parameter logic [7:0]  BASE_PAGE = 8'h03,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = DEFAULT_ERR_DATA
) (
  input  logic                  clk,
  input  logic                  resetn,
  iomem_bus_ctrl_if.slave       iomem,
  output logic [NSLOT-1:0]      sl_valid,
  output logic [3:0]            sl_wstrb,
  output logic [23:0]           sl_addr,
  output logic [31:0]           sl_wdata,
  input  logic [NSLOT-1:0]      sl_ready,
  input  logic [32*NSLOT-1:0]   sl_rdata,
  output logic                  err_irq,
  output logic [31:0]           err_addr,
  output logic [7:0]            err_count
);

  localparam int               IDXW         = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam logic [NSLOT-1:0] SLOT0        = NSLOT'(1);
  localparam logic [15:0]      TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t          state;
  logic [15:0]     timer;
  logic [IDXW-1:0] idx;
  logic [31:0]     req_addr;
  logic            req_hit;
  logic [IDXW-1:0] req_idx;
  logic            sel_ack;
  logic [31:0]     sel_rdata;

  assign req_hit = page_hit(iomem.iomem_addr[31:24], BASE_PAGE, NSLOT);
  assign req_idx = IDXW'(iomem.iomem_addr[31:24] - BASE_PAGE);
  assign sl_addr = req_addr[23:0];

  // sl_valid is one-hot, so masking with it discards acks from idle slots.
  assign sel_ack = |(sl_ready & sl_valid);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (idx == IDXW'(i)) begin
        sel_rdata = sl_rdata[32*i +: 32];
      end
    end
  end

  // Error bookkeeping is done on entry to ERR so err_irq lines up with the ERR
  // cycle; the response data and ready strobe are loaded on the way out of ERR.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state             <= IDLE;
      timer             <= '0;
      idx               <= '0;
      req_addr          <= '0;
      sl_valid          <= '0;
      sl_wstrb          <= '0;
      sl_wdata          <= '0;
      iomem.iomem_ready <= 1'b0;
      iomem.iomem_rdata <= '0;
      err_irq           <= 1'b0;
      err_addr          <= '0;
      err_count         <= '0;
    end else begin
      iomem.iomem_ready <= 1'b0;
      err_irq           <= 1'b0;
      case (state)
        IDLE: begin
          if (iomem.iomem_valid) begin
            if (req_hit) begin
              req_addr <= iomem.iomem_addr;
              sl_wstrb <= iomem.iomem_wstrb;
              sl_wdata <= iomem.iomem_wdata;
              idx      <= req_idx;
              sl_valid <= SLOT0 << req_idx;
              timer    <= '0;
              state    <= WAIT;
            end else begin
              err_irq  <= 1'b1;
              err_addr <= iomem.iomem_addr;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
              state    <= ERR;
            end
          end
        end
        WAIT: begin
          if (sel_ack) begin
            iomem.iomem_rdata <= sel_rdata;
            iomem.iomem_ready <= 1'b1;
            sl_valid          <= '0;
            state             <= RESP;
          end else if (timer == TIMEOUT_LAST) begin
            sl_valid <= '0;
            err_irq  <= 1'b1;
            err_addr <= req_addr;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            state    <= ERR;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        ERR: begin
          iomem.iomem_rdata <= ERR_DATA;
          iomem.iomem_ready <= 1'b1;
          state             <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
